// File: rtl/mr_wb_pkg.sv
// Shared widths and constants for the writeback stage and register file.
package mr_wb_pkg;
    localparam int XLEN        = 32;
    localparam int REGSEL_BITS = 5;
    localparam int NUM_REGS    = 1 << REGSEL_BITS;
    localparam int RETIRE_W    = 64;

    localparam logic [REGSEL_BITS-1:0] REG_ZERO = '0;

    typedef logic [XLEN-1:0]        xlen_t;
    typedef logic [REGSEL_BITS-1:0] regsel_t;
endpackage

// File: rtl/mr_wb_if.sv
// Writeback, decode-read and issue signals between the pipeline and mr_wb.
interface mr_wb_if;
    import mr_wb_pkg::*;

    // writeback from load/store
    logic                wb_write_i;
    xlen_t               wb_payload_i;
    regsel_t             wb_dst_reg_i;
    // decode read ports
    regsel_t             rd_a_sel_i;
    regsel_t             rd_b_sel_i;
    xlen_t               rd_a_o;
    xlen_t               rd_b_o;
    logic                rd_a_busy_o;
    logic                rd_b_busy_o;
    // decode issue claim
    logic                issue_valid_i;
    regsel_t             issue_dst_i;
    logic                issue_dst_busy_o;
    // statistics
    logic [RETIRE_W-1:0] retire_count_o;

    modport master (
        output wb_write_i, wb_payload_i, wb_dst_reg_i,
        output rd_a_sel_i, rd_b_sel_i, issue_valid_i, issue_dst_i,
        input  rd_a_o, rd_b_o, rd_a_busy_o, rd_b_busy_o,
        input  issue_dst_busy_o, retire_count_o
    );

    modport slave (
        input  wb_write_i, wb_payload_i, wb_dst_reg_i,
        input  rd_a_sel_i, rd_b_sel_i, issue_valid_i, issue_dst_i,
        output rd_a_o, rd_b_o, rd_a_busy_o, rd_b_busy_o,
        output issue_dst_busy_o, retire_count_o
    );
endinterface

// File: rtl/mr_wb_scoreboard.sv
// Per-register pending-writeback bits; a new claim beats a landing writeback.
module mr_scoreboard
    import mr_wb_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    issue_valid,
    input  regsel_t issue_dst,
    input  logic    wb_write,
    input  regsel_t wb_dst,
    input  regsel_t sel_a,
    input  regsel_t sel_b,
    output logic    busy_a,
    output logic    busy_b,
    output logic    busy_issue
);
    logic [NUM_REGS-1:0] sb_q;
    logic [NUM_REGS-1:0] sb_d;

    // clear on writeback first, then set on issue so the claim wins; x0 never busy
    always_comb begin
        sb_d = sb_q;
        if (wb_write)
            sb_d[wb_dst] = 1'b0;
        if (issue_valid && issue_dst != REG_ZERO)
            sb_d[issue_dst] = 1'b1;
        sb_d[0] = 1'b0;
    end

    // scoreboard state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sb_q <= '0;
        else
            sb_q <= sb_d;
    end

    // a writeback landing this cycle satisfies the dependency when forwarded
    function automatic logic busy_of(input regsel_t sel);
        if (BYPASS && wb_write && wb_dst == sel)
            return 1'b0;
        return sb_q[sel];
    endfunction

    assign busy_a     = busy_of(sel_a);
    assign busy_b     = busy_of(sel_b);
    assign busy_issue = busy_of(issue_dst);
endmodule

// File: rtl/mr_wb.sv
// Writeback stage: 31-entry register file, bypassed read ports, scoreboard, retire counter.
module mr_wb
    import mr_wb_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  logic    clk,
    input  logic    rst,
    mr_wb_if.slave  bus
);
    logic [1:0]          rst_sync_q;
    logic                rst_n_sync;
    xlen_t               regs_q [NUM_REGS];
    logic [RETIRE_W-1:0] retire_q;

    // assert asynchronously, release after two clean edges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rst_sync_q <= '0;
        else
            rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_sync = rst_sync_q[1];

    // commit writebacks; entry 0 stays at its reset value forever
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
        end else if (bus.wb_write_i && bus.wb_dst_reg_i != REG_ZERO) begin
            regs_q[bus.wb_dst_reg_i] <= bus.wb_payload_i;
        end
    end

    // every writeback pulse retires, x0 included; wraps naturally
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync)
            retire_q <= '0;
        else if (bus.wb_write_i)
            retire_q <= retire_q + 1'b1;
    end

    function automatic xlen_t read_port(input regsel_t sel);
        if (sel == REG_ZERO)
            return '0;
        if (BYPASS && bus.wb_write_i && bus.wb_dst_reg_i == sel)
            return bus.wb_payload_i;
        return regs_q[sel];
    endfunction

    assign bus.rd_a_o         = read_port(bus.rd_a_sel_i);
    assign bus.rd_b_o         = read_port(bus.rd_b_sel_i);
    assign bus.retire_count_o = retire_q;

    mr_scoreboard #(.BYPASS(BYPASS)) u_sb (
        .clk         (clk),
        .rst_n       (rst_n_sync),
        .issue_valid (bus.issue_valid_i),
        .issue_dst   (bus.issue_dst_i),
        .wb_write    (bus.wb_write_i),
        .wb_dst      (bus.wb_dst_reg_i),
        .sel_a       (bus.rd_a_sel_i),
        .sel_b       (bus.rd_b_sel_i),
        .busy_a      (bus.rd_a_busy_o),
        .busy_b      (bus.rd_b_busy_o),
        .busy_issue  (bus.issue_dst_busy_o)
    );

`ifdef FORMAL
    // decode must never claim a register that is still pending
    always @(posedge clk) begin
        if (rst_n_sync)
            assert (!(bus.issue_valid_i && bus.issue_dst_busy_o));
    end
`endif
endmodule

// File: doc/mr_wb.md
# mr_wb

Writeback stage and architectural register file, directly downstream of the load/store stage. It consumes the single-cycle writeback pulse (`wb_write`, payload, destination register) and commits it to a 31-entry XLEN register file; x0 is hardwired to zero. It serves decode with two combinational read ports that bypass same-cycle writebacks. A per-register scoreboard lets decode stall on registers with an in-flight writeback, and a 64-bit retire counter counts every writeback pulse.

## Interface
- `BYPASS`, default 1: when 1, a same-cycle writeback is forwarded to the read ports and masks scoreboard busy; when 0, there is no forwarding.
- Widths come from the shared macros: `XLEN` = 32 and `REGSEL_BITS` = 5.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wb_write_i`  in  1  writeback strobe; one commit per asserted cycle; no stall path.
- `wb_payload_i`  in  XLEN  value to commit.
- `wb_dst_reg_i`  in  REGSEL_BITS  destination register; 0 means discard the value.
- `rd_a_sel_i`, `rd_b_sel_i`  in  REGSEL_BITS  read port selects.
- `rd_a_o`, `rd_b_o`  out  XLEN  read data (combinational).
- `rd_a_busy_o`, `rd_b_busy_o`  out  1  selected register has a writeback pending.
- `issue_valid_i`  in  1  decode dispatched an instruction that will write `issue_dst_i`.
- `issue_dst_i`  in  REGSEL_BITS  claimed destination register.
- `issue_dst_busy_o`  out  1  scoreboard bit of `issue_dst_i` (WAW check).
- `retire_count_o`  out  64  number of `wb_write_i` pulses since reset.

## Operation
- Register file:
  - `regs[1..31]` is XLEN wide and resets to 0.
  - A write occurs when `wb_write_i` is high and `wb_dst_reg_i` != 0.
  - Reads of select 0 return 0.
- Bypass (`BYPASS` = 1): if `wb_write_i` is high and `wb_dst_reg_i` equals the read select and is nonzero, the read port returns `wb_payload_i` in the same cycle.
- Scoreboard `sb[1..31]`:
  - Resets to 0.
  - Set on the edge where `issue_valid_i` is high and `issue_dst_i` != 0.
  - Cleared on the edge where `wb_write_i` is high with that `wb_dst_reg_i`.
  - `sb[0]` is constant 0.
- Simultaneous set and clear of the same register: set wins and the bit stays 1. This covers a new claim issued while the old writeback lands.
- Busy outputs:
  - `BYPASS` = 1: `busy = sb[sel] & !(wb_write_i & wb_dst_reg_i == sel)`.
  - `BYPASS` = 0: `busy = sb[sel]`.
  - `issue_dst_busy_o` follows the same rule applied to `issue_dst_i`.
- Decode must not assert `issue_valid_i` while `issue_dst_busy_o` is high. This is enforced by an assertion under FORMAL.
- A writeback to a register whose scoreboard bit is clear is legal (stores, x0, unclaimed ALU ops). It commits normally and the scoreboard is unaffected.
- Retire counter:
  - `retire_count_o` increments by 1 per `wb_write_i` cycle, including x0 destinations.
  - It wraps from 2^64−1 to 0.

## Timing
- Writeback-to-read latency:
  - 0 cycles with bypass.
  - Without bypass, the value is visible via the array on the cycle after the commit edge.
- Issue-to-busy latency: 1 cycle. The scoreboard bit is visible on the cycle after `issue_valid_i`.
- Read outputs and busy outputs are purely combinational from selects, array, scoreboard and the writeback inputs.
- Reset state, effective immediately and asynchronously on `rst` falling:
  - all registers 0;
  - all scoreboard bits 0;
  - `retire_count_o` = 0.
  - Combinational outputs then read 0 and busy = 0 unless a writeback is driven.
- Reset deassertion is synchronised internally with a 2-flop release so that all state leaves reset on the same edge.
- A writeback and reset in the same cycle: reset wins and nothing is committed.

## Structure
- Shared package/config:
  - `XLEN`, `REGSEL_BITS`;
  - `REG_ZERO` = 0;
  - retire counter width constant `RETIRE_W` = 64.
- Natural sub-module: `mr_scoreboard`. It holds the 31 bits with set/clear priority and busy masking, and is instantiated with the `BYPASS` parameter.
- The register array is inferred flops (async reset required), not a RAM macro.

## Test plan
- Reset with `rst` = 0 mid-run after writing x5 = 0xDEADBEEF, then release → `rd_a_o` for x5 = 0, all busy = 0, `retire_count_o` = 0.
- Writeback x7 = 0x12345678 with `rd_a_sel_i` = 7 in the same cycle:
  - `BYPASS` = 1 → `rd_a_o` = 0x12345678 that cycle.
  - `BYPASS` = 0 → old value that cycle, 0x12345678 the next cycle.
- Writeback x0 = 0xFFFFFFFF → reads of x0 stay 0 and `retire_count_o` increments by 1.
- Issue x3, then 2 idle cycles, then writeback x3 = 0xA5 → `rd_b_busy_o` (sel = 3) is high in the 2 idle cycles, low in the writeback cycle (`BYPASS` = 1) with `rd_b_o` = 0xA5, and the scoreboard bit is cleared after.
- Same cycle: writeback x9 and `issue_valid_i` with `issue_dst_i` = 9 → the following cycle `issue_dst_busy_o` = 1 and x9 holds the written value.
- Preload `retire_count_o` to 2^64−2 via a backdoor force, then 3 writebacks → values 2^64−1, 0, 1.
